// File: rtl/apo_node_injector.sv
//------------------------------------------------------------------------------
// apo_node_injector : IP-side adapter injecting queued destinations into the
// circulant router's free input and counting tx/rx traffic.  Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module apo_node_injector #(
   parameter int NODES      = 16,
   parameter int K          = 5,
   parameter int N2         = 11,
   parameter int FIFO_DEPTH = 4,
   parameter int GAP        = 1,
   parameter int CNT_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [K-1:0]                  router_name,
   input  logic                          tx_valid,
   input  logic [K-1:0]                  tx_dest,
   output logic                          tx_ready,
   output logic                          tx_err,
   input  logic                          link_busy,
   output logic [N2-1:0]                 in_free,
   input  logic                          out_data,
   output logic                          rx_valid,
   output logic [CNT_W-1:0]              tx_count,
   output logic [CNT_W-1:0]              rx_count,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int GCW = (GAP > 1) ? $clog2(GAP) : 1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_INJECT = 2'd1;
   localparam logic [1:0] ST_GAP    = 2'd2;

   localparam logic [K:0]     c_nodes    = (K+1)'(NODES);
   localparam logic [AW:0]    c_full     = (AW+1)'(FIFO_DEPTH);
   localparam logic [GCW-1:0] c_gap_load = GCW'((GAP > 0) ? GAP - 1 : 0);

   logic [K-1:0]     r_mem [FIFO_DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_level;
   logic [1:0]       r_state;
   logic [GCW-1:0]   r_gap_cnt;
   logic [N2-1:0]    r_in_free;
   logic             r_tx_err;
   logic             r_rx_valid;
   logic [CNT_W-1:0] r_tx_count;
   logic [CNT_W-1:0] r_rx_count;

   logic             w_ready;
   logic             w_accept;
   logic             w_legal;
   logic             w_push;
   logic             w_pop;
   logic [N2-1:0]    w_pkt;
   logic             w_unused_name;

   // Self-addressed packets are counted like any other; the node number is
   // reserved for statistics qualification.
   assign w_unused_name = ^router_name;

   // Full-ness comes from the registered level only, so a coincident pop
   // never frees a slot for a push in the same cycle.
   assign w_ready  = (r_level != c_full);
   assign w_accept = tx_valid && w_ready;
   assign w_legal  = ({1'b0, tx_dest} < c_nodes);
   assign w_push   = w_accept && w_legal;

   assign w_pop = ((r_state == ST_IDLE) || ((GAP == 0) && (r_state == ST_INJECT)))
                  && (r_level != '0) && !link_busy;

   assign w_pkt = {1'b1, {(N2-1-K){1'b0}}, r_mem[r_rptr]};

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= tx_dest;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         if (w_push && !w_pop)      r_level <= r_level + 1'b1;
         else if (!w_push && w_pop) r_level <= r_level - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_gap_cnt <= '0;
         r_in_free <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_in_free <= w_pkt;
                  r_state   <= ST_INJECT;
               end else begin
                  r_in_free <= '0;
               end
            end
            ST_INJECT: begin
               if (GAP > 0) begin
                  r_in_free <= '0;
                  r_gap_cnt <= c_gap_load;
                  r_state   <= ST_GAP;
               end else if (w_pop) begin
                  r_in_free <= w_pkt;
               end else begin
                  r_in_free <= '0;
                  r_state   <= ST_IDLE;
               end
            end
            ST_GAP: begin
               r_in_free <= '0;
               if (r_gap_cnt == '0) r_state <= ST_IDLE;
               else                 r_gap_cnt <= r_gap_cnt - 1'b1;
            end
            default: begin
               r_in_free <= '0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_err   <= 1'b0;
         r_rx_valid <= 1'b0;
         r_tx_count <= '0;
         r_rx_count <= '0;
      end else begin
         r_tx_err   <= w_accept && !w_legal;
         r_rx_valid <= out_data;
         if (w_pop && (r_tx_count != '1))      r_tx_count <= r_tx_count + 1'b1;
         if (r_rx_valid && (r_rx_count != '1)) r_rx_count <= r_rx_count + 1'b1;
      end
   end

   assign tx_ready   = w_ready;
   assign tx_err     = r_tx_err;
   assign in_free    = r_in_free;
   assign rx_valid   = r_rx_valid;
   assign tx_count   = r_tx_count;
   assign rx_count   = r_rx_count;
   assign fifo_level = r_level;

endmodule

`default_nettype wire
